// File: rtl/wb_openram_multibank_pkg.sv
// Shared types and constants for the multi-bank Wishbone-to-OpenRAM bridge.
package wb_openram_multibank_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Bank index width; a single-bank build still carries one bank bit so bank 1 decodes as unpopulated.
    function automatic int bank_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_openram_multibank_if.sv
// Wishbone classic slave-side signal bundle between the caravel MI A port and the bridge.
interface wb_openram_multibank_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_openram_multibank_bank_mux.sv
// Selects one macro's 32-bit read word from the concatenated dout bus.
module openram_bank_mux #(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2
) (
    input  logic [NUM_BANKS*32-1:0] ram_dout0,
    input  logic [BANK_W-1:0]       bank,
    output logic [31:0]             dat_o
);

    always_comb begin
        dat_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank == BANK_W'(b)) dat_o = ram_dout0[32*b +: 32];
        end
    end

endmodule

// File: rtl/wb_openram_multibank.sv
// Wishbone classic slave bridging one address window onto NUM_BANKS OpenRAM 1RW macros.
//  state | meaning
//  IDLE  | waiting for a region hit; unpopulated bank answers with a one-cycle err
//  ISSUE | command presented to the macro, sampled on the edge leaving this state
//  RWAIT | waiting out read latency (writes pass through with a zero count)
//  RESP  | ack high for exactly this cycle
module wb_openram_multibank
    import wb_openram_multibank_pkg::*;
#(
    parameter int          NUM_BANKS = 4,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter int          READ_LAT  = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    wb_openram_multibank_if.slave   wbs,
    output logic                    ram_clk0,
    output logic [NUM_BANKS-1:0]    ram_csb0,
    output logic                    ram_web0,
    output logic [3:0]              ram_wmask0,
    output logic [ADDR_W-1:0]       ram_addr0,
    output logic [31:0]             ram_din0,
    input  logic [NUM_BANKS*32-1:0] ram_dout0
);

    localparam int BANK_W = bank_w(NUM_BANKS);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic                  we_q, we_d;
    logic [NUM_BANKS-1:0]  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           din_q, din_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           dat_q, dat_d;

    logic                  hit;
    logic [ADDR_W-1:0]     word_in;
    logic [BANK_W-1:0]     bank_in;
    logic [31:0]           mux_dat;

    assign hit     = wbs.wbs_stb_i & wbs.wbs_cyc_i & ((wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign word_in = wbs.wbs_adr_i[2 +: ADDR_W];
    assign bank_in = wbs.wbs_adr_i[2+ADDR_W +: BANK_W];

    openram_bank_mux #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_bank_mux (
        .ram_dout0 (ram_dout0),
        .bank      (bank_q),
        .dat_o     (mux_dat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        we_d    = we_q;
        csb_d   = '1;
        web_d   = 1'b1;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hit && !ack_q && !err_q) begin
                    if (int'(bank_in) >= NUM_BANKS) begin
                        err_d = 1'b1;
                    end else begin
                        for (int b = 0; b < NUM_BANKS; b++) begin
                            csb_d[b] = (bank_in != BANK_W'(b));
                        end
                        web_d   = ~wbs.wbs_we_i;
                        wmask_d = wbs.wbs_we_i ? wbs.wbs_sel_i : 4'h0;
                        addr_d  = word_in;
                        din_d   = wbs.wbs_dat_i;
                        bank_d  = bank_in;
                        we_d    = wbs.wbs_we_i;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    // Writes take one wait slot so their ack lines up with a READ_LAT=1 read.
                    cnt_d   = we_q ? '0 : CNT_W'(READ_LAT - 1);
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    if (!we_q) dat_d = mux_dat;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bank_q  <= '0;
            we_q    <= 1'b0;
            csb_q   <= '1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign ram_clk0      = wb_clk_i;
    assign ram_csb0      = csb_q;
    assign ram_web0      = web_q;
    assign ram_wmask0    = wmask_q;
    assign ram_addr0     = addr_q;
    assign ram_din0      = din_q;
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_err_o = err_q;
    assign wbs.wbs_dat_o = dat_q;

endmodule
